// File: rtl/music_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | music_pkg                                                                |
// | Shared constants and types for the keyboard / music-player design:       |
// | mode codes, note code markers, LED constant, controller state type and   |
// | small helpers used by the mode controller and its note sources.          |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
package music_pkg;

  // Mode codes, also shown on mode_state
  localparam logic [1:0] MODE_FREE  = 2'd0;
  localparam logic [1:0] MODE_AUTO  = 2'd1;
  localparam logic [1:0] MODE_LEARN = 2'd2;

  // Note code markers
  localparam logic [3:0] NOTE_REST = 4'h0;
  localparam logic [3:0] NOTE_END  = 4'hF;
  localparam logic [3:0] NOTE_MAX  = 4'd7;

  localparam logic [6:0] LED_OFF = 7'b0;

  // Active states share their encoding with the mode codes so the current
  // mode can be read straight from the state register.
  typedef enum logic [1:0] {
    ST_FREE  = 2'd0,
    ST_AUTO  = 2'd1,
    ST_LEARN = 2'd2,
    ST_MUTE  = 2'd3
  } ctrl_state_t;

  // One source's contribution to the shared buzzer/LED path
  typedef struct packed {
    logic [3:0] note;
    logic [1:0] octave;
    logic [6:0] led;
  } voice_t;

  // Next mode in the FREE -> AUTO -> LEARN -> FREE ring
  function automatic logic [1:0] mode_step_fwd(input logic [1:0] m);
    return (m == MODE_LEARN) ? MODE_FREE : m + 2'd1;
  endfunction

  // Previous mode in the ring
  function automatic logic [1:0] mode_step_back(input logic [1:0] m);
    return (m == MODE_FREE) ? MODE_LEARN : m - 2'd1;
  endfunction

  // Codes 8..14 are not playable; 1..7, rest and the end marker pass
  function automatic logic note_is_muted(input logic [3:0] n);
    return (n > NOTE_MAX) && (n != NOTE_END);
  endfunction

endpackage : music_pkg
`default_nettype wire

// File: rtl/mode_controller_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mode_controller_if                                                       |
// | Bundle between the mode controller and its surroundings.                 |
// |   mode_next / mode_prev        : mode buttons (levels)                   |
// |   <src>_note/_octave/_led      : note source data (free, auto, learn)    |
// |   en_free / en_auto / en_learn : one-hot source enables                  |
// |   note_to_play, octave_out,    : shared buzzer / LED outputs             |
// |   led_out                                                                |
// |   mode_state, switching        : current mode code, mute gap flag        |
// | master = environment side, slave = controller side.                      |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
interface mode_controller_if;
  import music_pkg::*;

  logic       mode_next;
  logic       mode_prev;

  logic [3:0] free_note;
  logic [3:0] auto_note;
  logic [3:0] learn_note;
  logic [1:0] free_octave;
  logic [1:0] auto_octave;
  logic [1:0] learn_octave;
  logic [6:0] free_led;
  logic [6:0] auto_led;
  logic [6:0] learn_led;

  logic       en_free;
  logic       en_auto;
  logic       en_learn;
  logic [3:0] note_to_play;
  logic [1:0] octave_out;
  logic [6:0] led_out;
  logic [1:0] mode_state;
  logic       switching;

  modport master (
    output mode_next, mode_prev,
    output free_note, auto_note, learn_note,
    output free_octave, auto_octave, learn_octave,
    output free_led, auto_led, learn_led,
    input  en_free, en_auto, en_learn,
    input  note_to_play, octave_out, led_out,
    input  mode_state, switching
  );

  modport slave (
    input  mode_next, mode_prev,
    input  free_note, auto_note, learn_note,
    input  free_octave, auto_octave, learn_octave,
    input  free_led, auto_led, learn_led,
    output en_free, en_auto, en_learn,
    output note_to_play, octave_out, led_out,
    output mode_state, switching
  );

endinterface : mode_controller_if
`default_nettype wire

// File: rtl/btn_edge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | btn_edge                                                                 |
// | Rising-edge detector for a button level.                                 |
// |   clk   : system clock                                                   |
// |   reset : synchronous active-high reset                                  |
// |   level : button level                                                   |
// |   pulse : high for the cycle where level is high and was low before      |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module btn_edge (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic pulse
);

  logic level_d;

  // Reset loads the live level so a button held through reset gives no edge
  always_ff @(posedge clk) begin
    if (reset) begin
      level_d <= level;
    end else begin
      level_d <= level;
    end
  end

  assign pulse = level & ~level_d;

endmodule : btn_edge
`default_nettype wire

// File: rtl/mode_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mode_controller                                                          |
// | Shares the buzzer / LED output path between the free-play, auto-play     |
// | and learn note sources. Button edges step the mode; every change passes  |
// | through a silent gap of MUTE_CYCLES clocks with all sources disabled.    |
// |   clk, reset : clock, synchronous active-high reset                      |
// |   bus        : mode_controller_if.slave (buttons, source data, enables,  |
// |                shared outputs, mode_state, switching)                    |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module mode_controller
  import music_pkg::*;
#(
  parameter int MUTE_CYCLES = 100000
) (
  input  logic clk,
  input  logic reset,
  mode_controller_if.slave bus
);

  localparam int CNT_W = $clog2(MUTE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUTE_CYCLES - 1);

  ctrl_state_t      state;
  logic [1:0]       target;
  logic [CNT_W-1:0] mute_cnt;

  logic             en_free_q;
  logic             en_auto_q;
  logic             en_learn_q;
  logic             switching_q;
  logic [1:0]       mode_q;
  voice_t           voice_q;

  logic             next_pulse;
  logic             prev_pulse;
  logic [1:0]       cur_mode;
  logic [1:0]       dest_mode;
  voice_t           sel_voice;
  voice_t           shaped_voice;

  btn_edge u_next_edge (
    .clk   (clk),
    .reset (reset),
    .level (bus.mode_next),
    .pulse (next_pulse)
  );

  btn_edge u_prev_edge (
    .clk   (clk),
    .reset (reset),
    .level (bus.mode_prev),
    .pulse (prev_pulse)
  );

  // Active state encodings equal the mode codes
  assign cur_mode  = state;
  // mode_next has priority when both buttons rise together
  assign dest_mode = next_pulse ? mode_step_fwd(cur_mode) : mode_step_back(cur_mode);

  // Source select and note filtering
  always_comb begin
    sel_voice = '0;
    case (state)
      ST_FREE:  sel_voice = '{note: bus.free_note,  octave: bus.free_octave,  led: bus.free_led};
      ST_AUTO:  sel_voice = '{note: bus.auto_note,  octave: bus.auto_octave,  led: bus.auto_led};
      ST_LEARN: sel_voice = '{note: bus.learn_note, octave: bus.learn_octave, led: bus.learn_led};
      default:  sel_voice = '0;
    endcase

    shaped_voice = sel_voice;
    if (note_is_muted(sel_voice.note)) begin
      shaped_voice.note = NOTE_REST;
      shaped_voice.led  = LED_OFF;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_FREE;
      target      <= MODE_FREE;
      mute_cnt    <= '0;
      en_free_q   <= 1'b1;
      en_auto_q   <= 1'b0;
      en_learn_q  <= 1'b0;
      switching_q <= 1'b0;
      mode_q      <= MODE_FREE;
      voice_q     <= '0;
    end else begin
      case (state)
        ST_MUTE: begin
          // Outputs stay silent for the whole gap, including the entry
          // cycle of the new mode; new data follows one cycle later.
          voice_q <= '0;
          if (mute_cnt == CNT_LAST) begin
            state       <= ctrl_state_t'(target);
            en_free_q   <= (target == MODE_FREE);
            en_auto_q   <= (target == MODE_AUTO);
            en_learn_q  <= (target == MODE_LEARN);
            switching_q <= 1'b0;
            mode_q      <= target;
          end else begin
            mute_cnt <= mute_cnt + CNT_W'(1);
          end
        end

        default: begin
          if (next_pulse || prev_pulse) begin
            state       <= ST_MUTE;
            target      <= dest_mode;
            mute_cnt    <= '0;
            en_free_q   <= 1'b0;
            en_auto_q   <= 1'b0;
            en_learn_q  <= 1'b0;
            switching_q <= 1'b1;
            mode_q      <= dest_mode;
            voice_q     <= '0;
          end else begin
            voice_q <= shaped_voice;
          end
        end
      endcase
    end
  end

  assign bus.en_free      = en_free_q;
  assign bus.en_auto      = en_auto_q;
  assign bus.en_learn     = en_learn_q;
  assign bus.switching    = switching_q;
  assign bus.mode_state   = mode_q;
  assign bus.note_to_play = voice_q.note;
  assign bus.octave_out   = voice_q.octave;
  assign bus.led_out      = voice_q.led;

endmodule : mode_controller
`default_nettype wire

// File: tb/tb_mode_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mode_controller                                                       |
// | Scoreboard bench for mode_controller with MUTE_CYCLES = 4. Stimulus is   |
// | driven on the falling edge; a mode-level reference model pushes the      |
// | expected outputs for the following rising edge, and a monitor pops and   |
// | compares them just after each rising edge.                               |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_mode_controller;

  localparam int MUTE = 4;

  typedef struct {
    logic [2:0] en;     // {learn, auto, free}
    logic [3:0] note;
    logic [1:0] oct;
    logic [6:0] led;
    logic [1:0] ms;
    logic       sw;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mode_controller_if bus ();

  mode_controller #(.MUTE_CYCLES(MUTE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  // Source data applied at the next step
  logic [3:0] s_note[3];
  logic [1:0] s_oct[3];
  logic [6:0] s_led[3];

  // Reference model: current mode, whether in the gap, cycles left in it
  int   m_mode;
  int   m_tgt;
  int   m_left;
  bit   m_mute;
  bit   m_pn;
  bit   m_pp;
  exp_t cur;

  task automatic model(input bit r, input bit n, input bit p);
    if (r) begin
      m_mode = 0; m_tgt = 0; m_mute = 0; m_left = 0;
      m_pn = n; m_pp = p;
      cur.en = 3'b001; cur.note = 0; cur.oct = 0; cur.led = 0; cur.ms = 0; cur.sw = 0;
    end else begin
      bit ne, pe;
      ne = n && !m_pn;
      pe = p && !m_pp;
      m_pn = n; m_pp = p;
      if (m_mute) begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_mute = 0;
          m_mode = m_tgt;
          cur.en = 3'(1 << m_mode);
          cur.sw = 0;
          cur.ms = 2'(m_mode);
        end
      end else if (ne || pe) begin
        m_tgt  = ne ? (m_mode + 1) % 3 : (m_mode + 2) % 3;
        m_mute = 1;
        m_left = MUTE;
        cur.en = 0; cur.note = 0; cur.oct = 0; cur.led = 0;
        cur.sw = 1;
        cur.ms = 2'(m_tgt);
      end else begin
        cur.note = s_note[m_mode];
        cur.oct  = s_oct[m_mode];
        cur.led  = s_led[m_mode];
        if (cur.note >= 8 && cur.note <= 14) begin
          cur.note = 0;
          cur.led  = 0;
        end
      end
    end
  endtask

  task automatic step(input bit r, input bit n, input bit p);
    @(negedge clk);
    reset            = r;
    bus.mode_next    = n;
    bus.mode_prev    = p;
    bus.free_note    = s_note[0];
    bus.auto_note    = s_note[1];
    bus.learn_note   = s_note[2];
    bus.free_octave  = s_oct[0];
    bus.auto_octave  = s_oct[1];
    bus.learn_octave = s_oct[2];
    bus.free_led     = s_led[0];
    bus.auto_led     = s_led[1];
    bus.learn_led    = s_led[2];
    model(r, n, p);
    sb.push_back(cur);
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  // Monitor
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        exp_t e;
        logic [2:0] en_act;
        e = sb.pop_front();
        en_act = {bus.en_learn, bus.en_auto, bus.en_free};
        checks++;
        if (en_act !== e.en || bus.note_to_play !== e.note || bus.octave_out !== e.oct ||
            bus.led_out !== e.led || bus.mode_state !== e.ms || bus.switching !== e.sw) begin
          failures++;
          $display("FAIL outputs t=%0t actual en=%b note=%h oct=%0d led=%b ms=%0d sw=%b required en=%b note=%h oct=%0d led=%b ms=%0d sw=%b",
                   $time, en_act, bus.note_to_play, bus.octave_out, bus.led_out, bus.mode_state, bus.switching,
                   e.en, e.note, e.oct, e.led, e.ms, e.sw);
        end
        checks++;
        if ($countones(en_act) > 1 || (en_act != 3'b000 && bus.switching === 1'b1)) begin
          failures++;
          $display("FAIL enable_invariant t=%0t actual en=%b sw=%b required at most one enable and none while switching",
                   $time, en_act, bus.switching);
        end
      end
    end
  end

  // Stimulus
  initial begin
    reset = 1'b1;
    bus.mode_next = 1'b0;
    bus.mode_prev = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_note[i] = '0; s_oct[i] = '0; s_led[i] = '0;
    end

    // mode_next held through reset, then released: no mode change
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    // Free-play data passes through with one cycle latency
    s_note[0] = 4'd3; s_oct[0] = 2'd1; s_led[0] = 7'b0000100;
    idle(2);

    // mode_next -> AUTO
    s_note[1] = 4'd5; s_oct[1] = 2'd2; s_led[1] = 7'b0010000;
    step(1'b0, 1'b1, 1'b0);
    idle(7);

    // Both buttons from AUTO -> LEARN, extra mode_next edge in the gap ignored
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    idle(6);

    // Filtered and end-marker notes in LEARN
    s_note[2] = 4'hA; s_oct[2] = 2'd3; s_led[2] = 7'h7F;
    idle(2);
    s_note[2] = 4'hF;
    idle(2);
    s_note[2] = 4'h8; idle(1);
    s_note[2] = 4'hE; idle(1);
    s_note[2] = 4'h7; idle(1);

    // mode_next from LEARN wraps to FREE
    step(1'b0, 1'b1, 1'b0);
    idle(6);

    // mode_prev from FREE wraps to LEARN, then mode_next back to FREE
    step(1'b0, 1'b0, 1'b1);
    idle(6);
    step(1'b0, 1'b1, 1'b0);
    idle(6);

    // Reset at the second gap cycle returns to FREE
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    idle(3);

    // Randomized traffic
    for (int k = 0; k < 600; k++) begin
      bit r, n, p;
      for (int i = 0; i < 3; i++) begin
        s_note[i] = 4'($urandom_range(0, 15));
        s_oct[i]  = 2'($urandom_range(0, 3));
        s_led[i]  = 7'($urandom_range(0, 127));
      end
      r = ($urandom_range(0, 79) == 0);
      n = ($urandom_range(0, 5) == 0);
      p = ($urandom_range(0, 6) == 0);
      step(r, n, p);
    end

    @(posedge clk);
    @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual pending=%0d required 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_mode_controller
`default_nettype wire

// File: doc/mode_controller.md
# mode_controller

Top-level mode controller for the keyboard/music-player design. It owns the single buzzer/LED output path and shares it between three note sources: free-play, auto-play and learn (`mode_learn`). Mode-button edges step a small state machine. Every mode change passes through a timed mute gap, and exactly one source is enabled at a time. The granted source's note, octave and LED pattern are registered onto the shared outputs.

## Interface
- `MUTE_CYCLES`, default 100000: length of the silent gap between modes, in clk cycles (≥1).
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous reset, active-high.
- `mode_next`  in  1  button; a rising edge advances the mode.
- `mode_prev`  in  1  button; a rising edge steps the mode back.
- `free_note` / `auto_note` / `learn_note`  in  4 each  source note codes.
- `free_octave` / `auto_octave` / `learn_octave`  in  2 each  source octaves.
- `free_led` / `auto_led` / `learn_led`  in  7 each  source LED patterns.
- `en_free` / `en_auto` / `en_learn`  out  1 each  one-hot source enables. A source whose enable is low holds itself at its start position.
- `note_to_play`  out  4  note to the buzzer driver.
- `octave_out`  out  2  octave to the buzzer driver.
- `led_out`  out  7  LED pattern.
- `mode_state`  out  2  mode code: 0 free, 1 auto, 2 learn.
- `switching`  out  1  high while in the mute gap.

## Operation
- **States:** FREE, AUTO, LEARN, MUTE. A `target` register (2 bits) holds the destination mode.
- **Reset values:**
  - state FREE, `target` = FREE.
  - `en_free`=1; `en_auto`, `en_learn`, `switching` = 0.
  - `note_to_play`, `octave_out`, `led_out` = 0; `mode_state` = 0.
  - Button history registers load the live button levels, so a button held through reset produces no edge.
- **Edge detect:** edge = current level high and previous-cycle level low. History updates every non-reset cycle, in all states.
- **Leaving an active mode:**
  - A `mode_next` edge sets `target` = current+1, with LEARN wrapping to FREE.
  - A `mode_prev` edge sets `target` = current−1, with FREE wrapping to LEARN.
  - Either edge moves the FSM to MUTE and clears the mute counter.
  - If both edges arrive in the same cycle, `mode_next` wins.
- **MUTE:**
  - All enables are 0. Outputs are forced to note 0, octave 0, LED 0. `switching`=1. `mode_state` shows `target`.
  - The counter increments each cycle. At count `MUTE_CYCLES`−1 the FSM enters `target` and raises that mode's enable.
  - Edges arriving during MUTE are ignored; there is no retargeting.
- **Output mux (active modes only):**
  - Outputs copy the granted source's note, octave and LED, registered.
  - Note filtering: codes 1–7 and 4'hF (end marker) pass through unchanged. Codes 8–14 map to 0, and the corresponding LED output is forced to 0 that cycle.
  - Octave passes through unchanged.
- **Invariant:** `en_*` has at most one bit set, and it is never set while `switching`=1.

## Timing
- Mux latency is 1 cycle: source inputs at cycle n appear on the outputs at cycle n+1.
- Edge sampled at cycle t:
  - At t+1: MUTE, enables 0, outputs 0, `switching`=1.
  - At t+1+`MUTE_CYCLES`: new mode active, its enable = 1, `switching`=0.
  - From t+2+`MUTE_CYCLES`: new source data appears on the outputs.
- **Reset mid-MUTE:** the next cycle is FREE with reset values. The counter and `target` are discarded.
- **Counter width:** `$clog2(MUTE_CYCLES+1)`. There is no overflow because the counter stops at the terminal count.

## Structure
- Shared package `music_pkg`:
  - mode encodings MODE_FREE=0, MODE_AUTO=1, MODE_LEARN=2;
  - NOTE_REST=4'h0, NOTE_END=4'hF, NOTE_MAX=4'd7, LED_OFF=7'b0.
  - `mode_learn` and the other sources use the same constants.
- Sub-module `btn_edge`:
  - ports clk, reset, level in, pulse out;
  - reset preloads the history register from `level`;
  - instantiated twice, once for `mode_next` and once for `mode_prev`.
- The FSM, mute counter and output mux live in `mode_controller`.

## Test plan
All scenarios use `MUTE_CYCLES`=4.
1. Reset, then `free_note`=3, `free_led`=7'b0000100 → `en_free`=1 and `note_to_play`=3, `led_out`=7'b0000100 one cycle after the inputs are applied.
2. `mode_next` pulse at cycle t → `switching`=1 and outputs 0 during t+1..t+4; at t+5 `en_auto`=1, `mode_state`=1; `auto_note`=5 appears at t+6.
3. From FREE, `mode_prev` pulse → `target` LEARN, and after the gap `en_learn`=1, `mode_state`=2. Then a `mode_next` pulse → wraps to FREE.
4. `mode_next` and `mode_prev` rise in the same cycle from AUTO → ends in LEARN. A second `mode_next` edge during MUTE is ignored, and the FSM still ends in LEARN.
5. Hold `mode_next` high through reset and release it → no mode change. Assert reset at the second MUTE cycle → FREE, `en_free`=1, all outputs 0.
6. In LEARN, `learn_note`=4'hA → `note_to_play`=0 and `led_out`=0. `learn_note`=4'hF → 4'hF passes through. At no cycle is more than one `en_*` high.
